prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 99 +++++++++
 tb/tb_prog_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control of the instruction ROM
// address, decoder mode feedback, completion flag and a saturating cycle count.
module prog_sequencer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Hold,
    input  logic       BranchEn,
    input  logic [8:0] BranchTarget,
    input  logic [1:0] NextState,
    input  logic [8:0] PrevInstructionOut,
    input  logic       DoneIn,
    output logic [8:0] ProgCtr,
    output logic [1:0] CurrState,
    output logic [8:0] PrevInstruction,
    output logic       Running,
    output logic       Ack,
    output logic [15:0] CycleCount
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  pc_q, pc_d;
    logic [1:0]  cs_q, cs_d;
    logic [8:0]  prev_q, prev_d;
    logic        ack_q, ack_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;

    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cs_d    = cs_q;
        prev_d  = prev_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = 9'd0;
                    cs_d    = 2'b00;
                    prev_d  = 9'd0;
                    ack_d   = 1'b0;
                    cnt_d   = 16'd0;
                end
            end
            RUN: begin
                if (!Hold) begin
                    cnt_d = cnt_inc;
                    if (DoneIn) begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                        cs_d    = 2'b00;
                    end else begin
                        pc_d   = BranchEn ? BranchTarget : pc_q + 9'd1;
                        // Reserved mode 11 degrades to regular sequencing
                        cs_d   = (NextState == 2'b11) ? 2'b00 : NextState;
                        prev_d = PrevInstructionOut;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= 9'd0;
            cs_q    <= 2'b00;
            prev_q  <= 9'd0;
            ack_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cs_q    <= cs_d;
            prev_q  <= prev_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ProgCtr         = pc_q;
    assign CurrState       = cs_q;
    assign PrevInstruction = prev_q;
    assign Running         = (state_q == RUN);
    assign Ack             = ack_q;
    assign CycleCount      = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed vector bench for prog_sequencer: table of edge-by-edge
// stimulus/expectations plus hand sequences for reset and saturation.
module tb_prog_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start, Hold, BranchEn, DoneIn;
    logic [8:0]  BranchTarget, PrevInstructionOut;
    logic [1:0]  NextState;
    logic [8:0]  ProgCtr, PrevInstruction;
    logic [1:0]  CurrState;
    logic        Running, Ack;
    logic [15:0] CycleCount;

    int nvec = 0;
    int nerr = 0;

    prog_sequencer dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Hold(Hold),
        .BranchEn(BranchEn),
        .BranchTarget(BranchTarget),
        .NextState(NextState),
        .PrevInstructionOut(PrevInstructionOut),
        .DoneIn(DoneIn),
        .ProgCtr(ProgCtr),
        .CurrState(CurrState),
        .PrevInstruction(PrevInstruction),
        .Running(Running),
        .Ack(Ack),
        .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        start;
        logic        hold;
        logic        ben;
        logic [8:0]  btgt;
        logic [1:0]  ns;
        logic [8:0]  pio;
        logic        done;
        logic [8:0]  e_pc;
        logic [1:0]  e_cs;
        logic [8:0]  e_pv;
        logic        e_run;
        logic        e_ack;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [8:0] pc,
                         input logic [1:0] cs, input logic [8:0] pv,
                         input logic run, input logic ack,
                         input logic [15:0] cnt);
        nvec++;
        if ({ProgCtr, CurrState, PrevInstruction, Running, Ack, CycleCount}
            !== {pc, cs, pv, run, ack, cnt}) begin
            nerr++;
            $display("FAIL %s: got pc=%h cs=%b pv=%h run=%b ack=%b cnt=%h, want pc=%h cs=%b pv=%h run=%b ack=%b cnt=%h",
                     name, ProgCtr, CurrState, PrevInstruction, Running, Ack,
                     CycleCount, pc, cs, pv, run, ack, cnt);
        end
    endtask

    task automatic drive(input logic st, input logic hd, input logic be,
                         input logic [8:0] bt, input logic [1:0] ns,
                         input logic [8:0] pio, input logic dn);
        Start = st; Hold = hd; BranchEn = be; BranchTarget = bt;
        NextState = ns; PrevInstructionOut = pio; DoneIn = dn;
    endtask

    initial begin
        // Inputs then expected outputs after the edge
        // st hd be btgt    ns     pio     dn   pc      cs     pv      run  ack  cnt
        tbl.push_back(vec_t'{0,0,0,9'h000,2'b00,9'h000,0, 9'h000,2'b00,9'h000,0,0,16'd0});
        tbl.push_back(vec_t'{1,1,1,9'h0A0,2'b01,9'h0FF,1, 9'h000,2'b00,9'h000,1,0,16'd0});
        tbl.push_back(vec_t'{0,0,0,9'h000,2'b00,9'h011,0, 9'h001,2'b00,9'h011,1,0,16'd1});
        tbl.push_back(vec_t'{1,0,0,9'h000,2'b00,9'h012,0, 9'h002,2'b00,9'h012,1,0,16'd2});
        tbl.push_back(vec_t'{0,0,0,9'h000,2'b00,9'h013,0, 9'h003,2'b00,9'h013,1,0,16'd3});
        tbl.push_back(vec_t'{0,0,0,9'h000,2'b00,9'h014,0, 9'h004,2'b00,9'h014,1,0,16'd4});
        tbl.push_back(vec_t'{0,0,0,9'h000,2'b00,9'h015,0, 9'h005,2'b00,9'h015,1,0,16'd5});
        tbl.push_back(vec_t'{0,0,1,9'h0A0,2'b01,9'h1FF,1, 9'h005,2'b00,9'h015,0,1,16'd6});
        tbl.push_back(vec_t'{0,1,1,9'h0A0,2'b10,9'h1FF,1, 9'h005,2'b00,9'h015,0,1,16'd6});
        tbl.push_back(vec_t'{1,0,0,9'h000,2'b00,9'h000,0, 9'h000,2'b00,9'h000,1,0,16'd0});
        tbl.push_back(vec_t'{0,0,0,9'h000,2'b00,9'h021,0, 9'h001,2'b00,9'h021,1,0,16'd1});
        tbl.push_back(vec_t'{0,0,0,9'h000,2'b00,9'h022,0, 9'h002,2'b00,9'h022,1,0,16'd2});
        tbl.push_back(vec_t'{0,0,0,9'h000,2'b00,9'h023,0, 9'h003,2'b00,9'h023,1,0,16'd3});
        tbl.push_back(vec_t'{0,0,1,9'h0A0,2'b01,9'h0AB,0, 9'h0A0,2'b01,9'h0AB,1,0,16'd4});
        tbl.push_back(vec_t'{0,0,1,9'h1FF,2'b10,9'h0AC,0, 9'h1FF,2'b10,9'h0AC,1,0,16'd5});
        tbl.push_back(vec_t'{0,0,0,9'h000,2'b11,9'h0AD,0, 9'h000,2'b00,9'h0AD,1,0,16'd6});
        tbl.push_back(vec_t'{0,0,1,9'h003,2'b01,9'h0AE,0, 9'h003,2'b01,9'h0AE,1,0,16'd7});
        tbl.push_back(vec_t'{0,1,1,9'h0A0,2'b10,9'h1AA,1, 9'h003,2'b01,9'h0AE,1,0,16'd7});
        tbl.push_back(vec_t'{0,1,1,9'h0A0,2'b10,9'h1AA,1, 9'h003,2'b01,9'h0AE,1,0,16'd7});
        tbl.push_back(vec_t'{0,1,1,9'h0A0,2'b10,9'h1AA,1, 9'h003,2'b01,9'h0AE,1,0,16'd7});
        tbl.push_back(vec_t'{0,0,1,9'h0A0,2'b10,9'h1AA,1, 9'h003,2'b00,9'h0AE,0,1,16'd8});
        tbl.push_back(vec_t'{0,1,1,9'h055,2'b01,9'h155,1, 9'h003,2'b00,9'h0AE,0,1,16'd8});
        tbl.push_back(vec_t'{1,0,0,9'h000,2'b00,9'h000,0, 9'h000,2'b00,9'h000,1,0,16'd0});
        tbl.push_back(vec_t'{0,0,0,9'h000,2'b00,9'h055,0, 9'h001,2'b00,9'h055,1,0,16'd1});

        drive(0, 0, 0, 9'h000, 2'b00, 9'h000, 0);
        Reset = 1'b0;
        #12;
        check("reset_state", 9'h000, 2'b00, 9'h000, 0, 0, 16'd0);
        @(negedge Clk);
        Reset = 1'b1;

        foreach (tbl[i]) begin
            @(negedge Clk);
            drive(tbl[i].start, tbl[i].hold, tbl[i].ben, tbl[i].btgt,
                  tbl[i].ns, tbl[i].pio, tbl[i].done);
            @(posedge Clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_cs,
                  tbl[i].e_pv, tbl[i].e_run, tbl[i].e_ack, tbl[i].e_cnt);
        end

        // Async reset mid-RUN, between edges
        @(negedge Clk);
        drive(0, 0, 1, 9'h123, 2'b10, 9'h0EE, 0);
        @(posedge Clk);
        #1;
        check("pre_reset_run", 9'h123, 2'b10, 9'h0EE, 1, 0, 16'd2);
        #2;
        Reset = 1'b0;
        #1;
        check("async_reset", 9'h000, 2'b00, 9'h000, 0, 0, 16'd0);
        @(posedge Clk);
        #1;
        check("reset_held", 9'h000, 2'b00, 9'h000, 0, 0, 16'd0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) begin
            @(posedge Clk);
            #1;
            check("post_reset_idle", 9'h000, 2'b00, 9'h000, 0, 0, 16'd0);
        end

        // Saturation of the RUN cycle counter
        @(negedge Clk);
        drive(1, 0, 0, 9'h000, 2'b00, 9'h000, 0);
        @(negedge Clk);
        drive(0, 0, 0, 9'h000, 2'b00, 9'h000, 0);
        repeat (65600) @(posedge Clk);
        #1;
        nvec++;
        if (CycleCount !== 16'hFFFF || Running !== 1'b1) begin
            nerr++;
            $display("FAIL saturate: got cnt=%h run=%b, want cnt=ffff run=1",
                     CycleCount, Running);
        end
        repeat (20) @(posedge Clk);
        #1;
        nvec++;
        if (CycleCount !== 16'hFFFF) begin
            nerr++;
            $display("FAIL saturate_hold: got cnt=%h, want cnt=ffff", CycleCount);
        end
        @(negedge Clk);
        DoneIn = 1'b1;
        @(posedge Clk);
        #1;
        nvec++;
        if (CycleCount !== 16'hFFFF || Ack !== 1'b1 || Running !== 1'b0) begin
            nerr++;
            $display("FAIL saturate_done: got cnt=%h ack=%b run=%b, want cnt=ffff ack=1 run=0",
                     CycleCount, Ack, Running);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
